// File: rtl/edge_pkg.sv
// edge_pkg: shared defaults, window index constants, packing helper and FSM states for window_streamer
package edge_pkg;
  localparam int COLDEPTH_DEFAULT = 8;
  localparam int WIN_DIM = 3;
  localparam int WIN_TAPS = WIN_DIM * WIN_DIM;
  function automatic int win_lsb(input int k, input int cd);
    return (WIN_TAPS - 1 - k) * cd;
  endfunction
  typedef enum logic [1:0] {S_FILL, S_RUN, S_LAST} state_t;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image row; combinational read and clocked write share an address, so the read sees the old value
module line_buffer
  import edge_pkg::*;
#(
  parameter int Image_width = 64,
  parameter int COLDepth = COLDEPTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(Image_width)-1:0] addr,
  input  logic [COLDepth-1:0]            wd,
  output logic [COLDepth-1:0]            rd
);
  logic [COLDepth-1:0] mem_q [Image_width];
  assign rd = mem_q[addr];
  // row storage, overwritten column by column as pixels are accepted
  always_ff @(posedge clk) if (we) mem_q[addr] <= wd;
endmodule

// File: rtl/window_streamer.sv
// window_streamer: raster pixels in, packed 3x3 interior windows out; defining WIN_SOF_CHECK_EN adds the sticky sof_err output
module window_streamer
  import edge_pkg::*;
#(
  parameter int COLDepth = COLDEPTH_DEFAULT,
  parameter int Image_width = 64,
  parameter int Image_height = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [COLDepth-1:0]             pix_in,
  input  logic                            pix_sof,
  input  logic                            pix_valid,
  output logic                            pix_ready,
  output logic [WIN_TAPS*COLDepth-1:0]    Pixels_In_Grayscale,
  output logic [$clog2(Image_width)-1:0]  win_x,
  output logic [$clog2(Image_height)-1:0] win_y,
  output logic                            win_last,
  output logic                            win_valid,
`ifdef WIN_SOF_CHECK_EN
  output logic                            sof_err,
`endif
  input  logic                            win_ready
);
  localparam int XW = $clog2(Image_width);
  localparam int YW = $clog2(Image_height);
  state_t state_q, state_d;
  logic [XW-1:0] x_q, ex, ex_n;
  logic [YW-1:0] y_q, ey, ey_n;
  logic acc, emit, x_end, y_end;
  logic [COLDepth-1:0] lb0_rd, lb1_rd;
  logic [WIN_DIM-1:0][COLDepth-1:0] cl_q, cm_q, cn;
  logic [WIN_TAPS*COLDepth-1:0] win;
  assign pix_ready = state_q != S_LAST && (!win_valid || win_ready);
  assign acc = pix_valid && pix_ready;
  assign ex = pix_sof ? '0 : x_q;
  assign ey = pix_sof ? '0 : y_q;
  assign x_end = ex == XW'(Image_width - 1);
  assign y_end = ey == YW'(Image_height - 1);
  assign ex_n = x_end ? '0 : ex + 1'b1;
  assign ey_n = x_end ? (y_end ? '0 : ey + 1'b1) : ey;
  assign emit = acc && ex >= XW'(2) && ey >= YW'(2);
  assign cn = {pix_in, lb0_rd, lb1_rd};
  line_buffer #(.Image_width(Image_width), .COLDepth(COLDepth)) u_lb0 (
    .clk(clk), .we(acc), .addr(ex), .wd(pix_in), .rd(lb0_rd)
  );
  line_buffer #(.Image_width(Image_width), .COLDepth(COLDepth)) u_lb1 (
    .clk(clk), .we(acc), .addr(ex), .wd(lb0_rd), .rd(lb1_rd)
  );
  for (genvar r = 0; r < WIN_DIM; r++) begin : g_row
    for (genvar c = 0; c < WIN_DIM; c++) begin : g_col
      localparam int L = win_lsb(WIN_DIM * r + c, COLDepth);
      assign win[L +: COLDepth] = c == 0 ? cl_q[r] : c == 1 ? cm_q[r] : cn[r];
    end
  end
  // state register
  always_ff @(posedge clk) state_q <= reset ? S_FILL : state_d;
  // next state: the final window blocks input until taken; otherwise the row of the next pixel decides
  always_comb begin
    state_d = state_q;
    if (state_q == S_LAST) state_d = win_ready ? S_FILL : S_LAST;
    else if (acc) state_d = (emit && x_end && y_end) ? S_LAST : ey_n >= YW'(2) ? S_RUN : S_FILL;
  end
  // raster counters and the one-deep output register
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
      win_valid <= 1'b0;
      win_last <= 1'b0;
      win_x <= '0;
      win_y <= '0;
      Pixels_In_Grayscale <= '0;
    end else begin
      if (acc) begin
        x_q <= ex_n;
        y_q <= ey_n;
      end
      if (emit) begin
        win_valid <= 1'b1;
        win_last <= x_end && y_end;
        win_x <= ex - 1'b1;
        win_y <= ey - 1'b1;
        Pixels_In_Grayscale <= win;
      end else if (win_ready) win_valid <= 1'b0;
    end
  end
  // two previous columns of the 3-row neighbourhood; the current column comes straight from the line buffers
  always_ff @(posedge clk) begin
    if (acc) begin
      cl_q <= cm_q;
      cm_q <= cn;
    end
  end
`ifdef WIN_SOF_CHECK_EN
  logic done_q;
  // sticky frame-marker error: sof away from (0,0), or a missing sof at (0,0) once a frame has completed
  always_ff @(posedge clk) begin
    if (reset) begin
      sof_err <= 1'b0;
      done_q <= 1'b0;
    end else if (acc) begin
      if (x_end && y_end) done_q <= 1'b1;
      if (pix_sof ? (x_q != '0 || y_q != '0) : (x_q == '0 && y_q == '0 && done_q)) sof_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_window_streamer.sv
// tb_window_streamer: randomized and directed stimulus checked every cycle against a behavioural image model
module tb_window_streamer;
  localparam int W = 4;
  localparam int H = 4;
  localparam int CD = 8;
  localparam logic [71:0] FIRST_WIN = 72'h00010204050608090A;
  localparam logic [71:0] LAST_WIN = 72'h05060709_0A0B0D0E0F;
  logic clk = 1'b0, reset = 1'b1;
  logic [CD-1:0] pix_in = '0;
  logic pix_sof = 1'b0, pix_valid = 1'b0, pix_ready;
  logic [9*CD-1:0] Pixels_In_Grayscale;
  logic [1:0] win_x, win_y;
  logic win_last, win_valid, win_ready = 1'b1;
`ifdef WIN_SOF_CHECK_EN
  logic sof_err;
`endif
  int assertions = 0, failures = 0;
  logic wr_fixed = 1'b1, rnd = 1'b0;
  logic [CD-1:0] img [H][W];
  int px = 0, py = 0;
  logic mv = 1'b0, mlast = 1'b0;
  logic [71:0] mwin = '0;
  int mx = 0, my = 0;
  logic [71:0] rx_log[$], m_log[$];
  logic rx_lastf[$];

  window_streamer #(.COLDepth(CD), .Image_width(W), .Image_height(H)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_sof(pix_sof), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .Pixels_In_Grayscale(Pixels_In_Grayscale), .win_x(win_x), .win_y(win_y),
    .win_last(win_last), .win_valid(win_valid),
`ifdef WIN_SOF_CHECK_EN
    .sof_err(sof_err),
`endif
    .win_ready(win_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    win_ready = rnd ? 1'($urandom_range(0, 1)) : wr_fixed;
  end

  task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic monitor();
    logic exp_rdy;
    logic [71:0] w;
    forever begin
      @(negedge clk);
      if (reset) begin
        mv = 1'b0;
        mlast = 1'b0;
        px = 0;
        py = 0;
      end else begin
        exp_rdy = !(mv && mlast) && (!mv || win_ready);
        chk("pix_ready", 72'(pix_ready), 72'(exp_rdy));
        chk("win_valid", 72'(win_valid), 72'(mv));
        if (mv) begin
          chk("win_data", Pixels_In_Grayscale, mwin);
          chk("win_x", 72'(win_x), 72'(mx));
          chk("win_y", 72'(win_y), 72'(my));
          chk("win_last", 72'(win_last), 72'(mlast));
        end
        if (mv && win_ready) begin
          rx_log.push_back(Pixels_In_Grayscale);
          rx_lastf.push_back(win_last);
          m_log.push_back(mwin);
          mv = 1'b0;
        end
        if (pix_valid && exp_rdy) begin
          if (pix_sof) begin
            px = 0;
            py = 0;
          end
          img[py][px] = pix_in;
          if (px >= 2 && py >= 2) begin
            for (int k = 0; k < 9; k++) w[(8 - k) * CD +: CD] = img[py - 2 + k / 3][px - 2 + k % 3];
            mwin = w;
            mv = 1'b1;
            mx = px - 1;
            my = py - 1;
            mlast = (px == W - 1 && py == H - 1);
          end
          px++;
          if (px == W) begin
            px = 0;
            py = (py == H - 1) ? 0 : py + 1;
          end
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [CD-1:0] v, input logic s);
    int n = 0;
    logic acc_now;
    pix_in = v;
    pix_sof = s;
    pix_valid = 1'b1;
    do begin
      @(negedge clk);
      acc_now = pix_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc_now && n < 200);
    if (!acc_now) chk("push_timeout", 72'(acc_now), 72'(1));
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic pixels(input int from, input int to);
    for (int i = from; i <= to; i++) push(CD'(i), i == 0);
  endtask

  task automatic drain();
    int n = 0;
    rnd = 1'b0;
    wr_fixed = 1'b1;
    while ((mv || win_valid) && n < 100) begin
      cyc(1);
      n++;
    end
    chk("drain_timeout", 72'(n < 100), 72'(1));
    cyc(2);
  endtask

  initial begin
    int base;
    fork
      monitor();
    join_none
    cyc(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 72'(win_valid), 72'(0));
    chk("rst_last", 72'(win_last), 72'(0));
    chk("rst_data", Pixels_In_Grayscale, 72'(0));
    chk("rst_xy", 72'({win_x, win_y}), 72'(0));
    chk("rst_ready", 72'(pix_ready), 72'(1));
    cyc(1);
    base = rx_log.size();
    pixels(0, 15);
    drain();
    chk("s1_count", 72'(rx_log.size() - base), 72'(4));
    chk("s1_first", rx_log[base], FIRST_WIN);
    chk("s1_model_first", m_log[base], FIRST_WIN);
    chk("s1_last", rx_log[base + 3], LAST_WIN);
    chk("s1_model_last", m_log[base + 3], LAST_WIN);
    chk("s1_lastflag", 72'(rx_lastf[base + 3]), 72'(1));
    chk("s1_midflag", 72'(rx_lastf[base + 2]), 72'(0));
    base = rx_log.size();
    wr_fixed = 1'b0;
    cyc(2);
    pixels(0, 10);
    cyc(3);
    @(negedge clk);
    chk("hold_ready", 72'(pix_ready), 72'(0));
    chk("hold_valid", 72'(win_valid), 72'(1));
    chk("hold_data", Pixels_In_Grayscale, FIRST_WIN);
    cyc(1);
    wr_fixed = 1'b1;
    pixels(11, 15);
    drain();
    chk("s2_count", 72'(rx_log.size() - base), 72'(4));
    chk("s2_last", rx_log[base + 3], LAST_WIN);
    base = rx_log.size();
    pixels(0, 15);
    pixels(0, 15);
    drain();
    chk("s3_count", 72'(rx_log.size() - base), 72'(8));
    chk("s3_second_first", rx_log[base + 4], FIRST_WIN);
    chk("s3_second_last", rx_log[base + 7], LAST_WIN);
`ifdef WIN_SOF_CHECK_EN
    chk("sof_err_clean", 72'(sof_err), 72'(0));
`endif
    base = rx_log.size();
    pixels(0, 5);
    pixels(0, 15);
    drain();
    chk("s4_count", 72'(rx_log.size() - base), 72'(4));
    chk("s4_first", rx_log[base], FIRST_WIN);
`ifdef WIN_SOF_CHECK_EN
    chk("sof_err_set", 72'(sof_err), 72'(1));
`endif
    wr_fixed = 1'b0;
    cyc(2);
    pixels(0, 10);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("rst_drop", 72'(win_valid), 72'(0));
`ifdef WIN_SOF_CHECK_EN
    chk("sof_err_rst", 72'(sof_err), 72'(0));
`endif
    wr_fixed = 1'b1;
    cyc(2);
    base = rx_log.size();
    pixels(0, 15);
    drain();
    chk("s5_count", 72'(rx_log.size() - base), 72'(4));
    chk("s5_last", rx_log[base + 3], LAST_WIN);
    base = rx_log.size();
    rnd = 1'b1;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < W * H; i++) begin
        cyc($urandom_range(0, 2));
        push(CD'($urandom), i == 0);
      end
    end
    drain();
    chk("s6_count", 72'(rx_log.size() - base), 72'(80));
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule

// File: doc/window_streamer.md
# window_streamer

Raster-to-window generator that feeds the edge-detector convolution stage. Accepts one grayscale pixel per handshake in row-major order, keeps the two previous image rows in line buffers, and emits one packed 3x3 neighbourhood (`Pixels_In_Grayscale`, 72 bits at 8-bit colour) for every interior pixel. It is the producer end of the convolution block's window input.

## Interface
- `COLDepth`, 8: bits per pixel.
- `Image_width`, 64: pixels per row (≥3).
- `Image_height`, 64: rows per frame (≥3).

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pix_in`  in  COLDepth  input pixel.
- `pix_sof`  in  1  qualifies `pix_in` as pixel (0,0) of a new frame.
- `pix_valid`  in  1  input pixel present.
- `pix_ready`  out  1  block accepts input this cycle.
- `Pixels_In_Grayscale`  out  9*COLDepth  packed 3x3 window.
- `win_x`, `win_y`  out  $clog2(Image_width) / $clog2(Image_height)  window centre coordinates.
- `win_last`  out  1  window is the last of the frame.
- `win_valid`  out  1  window present.
- `win_ready`  in  1  consumer takes window.

## Operation
- Input accepted on `pix_valid && pix_ready`; output transferred on `win_valid && win_ready`.
- Counters x (0..W-1), y (0..H-1) give the accepted pixel's position; x wraps to 0 with y+1; after (W-1,H-1) both return to 0.
- An accepted pixel with `pix_sof`=1 is always treated as (0,0), regardless of counter state; any partial frame is abandoned and no windows of it are emitted afterwards.
- Line buffers: lb0 = row y-1, lb1 = row y-2. On accept at x: lb1[x] ← lb0[x], lb0[x] ← pix_in.
- Column shift register (3 columns). New column = {lb1[x], lb0[x], pix_in} (top, mid, bottom); oldest column discarded.
- Window emitted when the accepted pixel has x≥2 and y≥2; centre = (x-1, y-1). That gives (W-2)*(H-2) windows per frame; no border windows.
- Packing: element k = 3*row+col (row 0 = top, col 0 = left) occupies bits [(9-k)*COLDepth-1 -: COLDepth]. k=0 is in the MSBs, matching the convolution kernel index order.
- `win_last` is 1 only with the window centred at (W-2, H-2).
- States:
  - S_FILL: y<2. Pixels are accepted, no windows.
  - S_RUN: y≥2. Windows are emitted.
  - S_LAST: final window is held. `pix_ready`=0 until it is taken, then S_FILL.
  - Reset enters S_FILL with x=y=0.
  - An sof accept in any state forces S_FILL, except that a window already held in the output register is still delivered.
- Line-buffer RAM contents are not cleared by reset. They are overwritten before use.

## Timing
- One-deep output register. `pix_ready` = (state≠S_LAST) && (!win_valid || win_ready), which gives full throughput of 1 pixel/cycle when `win_ready`=1.
- Latency: `win_valid` rises the cycle after the qualifying pixel is accepted.
- Window data and coordinates stay stable while `win_valid && !win_ready`.
- Reset values: `win_valid`=0, `win_last`=0, `Pixels_In_Grayscale`=0, `win_x`=`win_y`=0. `pix_ready`=1 in the first cycle after reset.
- Simultaneous output-take and input-accept in the same cycle: the output register reloads with no bubble.
- Reset asserted mid-frame discards the held window and all counters.

## Configuration
- `WIN_SOF_CHECK_EN` defined:
  - Adds output `sof_err` (1 bit), which is sticky and cleared only by reset.
  - `sof_err` is set when `pix_sof`=1 is accepted while the counters are not at (0,0).
  - `sof_err` is also set when `pix_sof`=0 is accepted at (0,0) after a frame has completed.
  - Datapath behaviour is unchanged.
- Not defined: the port is absent and there is no check logic.

## Structure
- Shared package `edge_pkg`:
  - `COLDepth` default.
  - Window-index constants.
  - Packing function (k → bit slice).
  - State enum (S_FILL, S_RUN, S_LAST).
- Sub-module `line_buffer`: Image_width×COLDepth, one read and one write at the same address per cycle, read-before-write. It is instantiated twice.

## Test plan (W=H=4, pixel value = 4y+x)
- Stream 16 pixels with `win_ready`=1. Expect:
  - 4 windows, centres (1,1),(2,1),(1,2),(2,2).
  - First window = 0x000102040506080 90A, i.e. 0x00010204050608090A.
  - Last window = 0x0506070 90A0B0D0E0F, i.e. 0x05060709 0A0B0D0E0F with gaps removed, with `win_last`=1.
- Hold `win_ready`=0 after the first window → `pix_ready`=0, window stable; release → the remaining windows arrive in order with none lost.
- Two back-to-back frames, second starting with `pix_sof` → 8 windows total, and the second frame's windows are identical to the first's.
- `pix_sof` at pixel 6 of a frame → no window from the old frame, then 4 correct windows from the new frame; `sof_err`=1 when `WIN_SOF_CHECK_EN` is defined.
- Reset asserted while a window is held → next cycle `win_valid`=0; the following frame yields 4 correct windows.
- Random `pix_valid`/`win_ready` over 20 frames → compare against a scoreboard model: 80 windows, bit-exact.
